// File: rtl/debug_cmd_ctrl.sv
// UART debug command controller: decodes single-byte commands and drives processor run/step control, PC and cycle-counter readout.
// Latency: first tx_start is asserted 3 cycles after a command byte is captured (DECODE, LOAD, SEND); enable changes 2 edges after capture.
// Backpressure: every response byte waits for tx_done in WAIT_TX; command bytes that arrive while busy are dropped.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   rx_dato_out  received command byte, valid while rx_done=1
//   rx_done      RX byte-complete flag; a byte is its 0->1 transition
//   tx_done      TX byte-complete flag, only looked at in WAIT_TX
//   pc_value     program counter of the processor under debug
//   enable       registered processor clock-enable (run OR step)
//   tx_dato_in   byte to transmit, held from LOAD until tx_done
//   tx_start     one-cycle transmit request
//   busy         high whenever the controller is not idle
module debug_cmd_ctrl #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_dato_out,
   input  logic          rx_done,
   input  logic          tx_done,
   input  logic [DW-1:0] pc_value,
   output logic          enable,
   output logic [7:0]    tx_dato_in,
   output logic          tx_start,
   output logic          busy
);

   localparam int         NB   = DW / 8;
   localparam logic [2:0] NB_L = 3'(NB);

   localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
   localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
   localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
   localparam logic [7:0] CMD_PC   = 8'h70;  // 'p'
   localparam logic [7:0] CMD_CNT  = 8'h72;  // 'r'
   localparam logic [7:0] CMD_ZERO = 8'h7A;  // 'z'
   localparam logic [7:0] RSP_UNK  = 8'h3F;  // '?'

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      LOAD,
      SEND,
      WAIT_TX
   } state_t;

   state_t        state;
   logic [7:0]    cmd;
   logic          rx_done_q;
   logic          run;
   logic          step;
   logic [DW-1:0] cnt;
   logic [DW-1:0] shreg;     // response bytes, next byte in the top 8 bits
   logic [2:0]    left;      // response bytes still to be loaded

   logic          run_nxt;
   logic          step_nxt;
   logic          clr_cnt;
   logic          rx_rise;

   assign rx_rise = rx_done & ~rx_done_q;
   assign busy    = (state != IDLE);

   // Run/step/clear effects of the command being decoded. Computed here so
   // that enable can be registered from the same next-state values as
   // run and step, keeping enable == run | step at all times.
   always_comb begin
      run_nxt  = run;
      step_nxt = 1'b0;
      clr_cnt  = 1'b0;
      if (state == DECODE) begin
         case (cmd)
            CMD_RUN:  run_nxt  = 1'b1;
            CMD_HALT: run_nxt  = 1'b0;
            CMD_STEP: step_nxt = ~run;
            CMD_ZERO: clr_cnt  = 1'b1;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cmd        <= 8'h00;
         rx_done_q  <= 1'b0;
         run        <= 1'b0;
         step       <= 1'b0;
         enable     <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         left       <= 3'd0;
         tx_dato_in <= 8'h00;
         tx_start   <= 1'b0;
      end else begin
         rx_done_q <= rx_done;
         run       <= run_nxt;
         step      <= step_nxt;   // self-clears: only set out of DECODE
         enable    <= run_nxt | step_nxt;
         tx_start  <= 1'b0;

         // Clear beats the increment when 'z' decodes while running.
         if (clr_cnt)
            cnt <= '0;
         else if (enable)
            cnt <= cnt + DW'(1);

         case (state)
            IDLE: begin
               if (rx_rise) begin
                  cmd   <= rx_dato_out;
                  state <= DECODE;
               end
            end
            DECODE: begin
               case (cmd)
                  CMD_PC: begin
                     shreg <= pc_value;
                     left  <= NB_L;
                  end
                  CMD_CNT: begin
                     shreg <= cnt;
                     left  <= NB_L;
                  end
                  CMD_RUN, CMD_HALT, CMD_STEP, CMD_ZERO: begin
                     shreg <= DW'(cmd) << (DW - 8);
                     left  <= 3'd1;
                  end
                  default: begin
                     shreg <= DW'(RSP_UNK) << (DW - 8);
                     left  <= 3'd1;
                  end
               endcase
               state <= LOAD;
            end
            LOAD: begin
               tx_dato_in <= shreg[DW-1 -: 8];
               shreg      <= shreg << 8;
               left       <= left - 3'd1;
               tx_start   <= 1'b1;    // high during the SEND cycle
               state      <= SEND;
            end
            SEND: begin
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               if (tx_done)
                  state <= (left != 3'd0) ? LOAD : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Testbench for debug_cmd_ctrl: a 32-bit and an 8-bit instance share all inputs.
// Latency: responses are collected through a tx_start/tx_done handshake driven by the bench.
// Backpressure: tx_done is returned after a random delay for every transmitted byte.
module tb_debug_cmd_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_done;
   logic        tx_done;
   logic [7:0]  rx_dato_out;
   logic [31:0] pc_value;

   logic        enable, tx_start, busy;
   logic [7:0]  tx_dato_in;
   logic        en8, st8, busy8;
   logic [7:0]  dat8;

   always #5 clk = ~clk;

   debug_cmd_ctrl #(.DW(32)) dut (
      .clk(clk), .reset(reset), .rx_dato_out(rx_dato_out), .rx_done(rx_done),
      .tx_done(tx_done), .pc_value(pc_value), .enable(enable),
      .tx_dato_in(tx_dato_in), .tx_start(tx_start), .busy(busy)
   );

   debug_cmd_ctrl #(.DW(8)) dut8 (
      .clk(clk), .reset(reset), .rx_dato_out(rx_dato_out), .rx_done(rx_done),
      .tx_done(tx_done), .pc_value(pc_value[7:0]), .enable(en8),
      .tx_dato_in(dat8), .tx_start(st8), .busy(busy8)
   );

   int n_chk = 0;
   int n_pass = 0;

   // reference model: run flag, expected enable, 32-bit counter, pending decode
   bit          m_run = 0;
   bit          m_en = 0;
   bit          m_pend = 0;
   logic [7:0]  m_cmd = 8'h00;
   logic [31:0] m_cnt = 32'h0;

   // observation
   int          obs_n, obs8_n, hold_bad, st_bad, en_bad, en_hi, en_total, lat, exp_n;
   logic [31:0] obs_w, obs8_w, exp_w, exp8_w;
   bit          holding, st_prev, tmo, aborted;
   logic [7:0]  hold_v;
   logic        busy_after;

   task automatic cycle();
      bit fire, clr, td;
      @(posedge clk);
      td = tx_done; fire = 0; clr = 0;
      if (reset) begin
         m_run = 0; m_en = 0; m_cnt = 32'h0; m_pend = 0; holding = 0;
      end else begin
         if (m_pend) begin
            case (m_cmd)
               8'h63: m_run = 1;
               8'h68: m_run = 0;
               8'h73: fire = !m_run;
               8'h7A: clr = 1;
               default: ;
            endcase
            m_pend = 0;
         end
         if (clr) m_cnt = 32'h0;
         else if (m_en) m_cnt = m_cnt + 32'd1;
         m_en = m_run | fire;
      end
      #1;
      if (enable !== m_en || en8 !== m_en) en_bad++;
      if (enable === 1'b1) begin en_hi++; en_total++; end
      if (holding && tx_dato_in !== hold_v) hold_bad++;
      if (td) holding = 0;
      if (tx_start === 1'b1) begin
         if (st_prev) st_bad++;
         holding = 1; hold_v = tx_dato_in;
         obs_w = {obs_w[23:0], tx_dato_in}; obs_n++;
      end
      if (st8 === 1'b1) begin obs8_w = {obs8_w[23:0], dat8}; obs8_n++; end
      st_prev = (tx_start === 1'b1);
   endtask

   // Send one command byte (DUT assumed idle) and serve its response.
   task automatic do_cmd(input logic [7:0] b, input bit drop, input int rst_at);
      logic [31:0] latch;
      int w;
      obs_n = 0; obs8_n = 0; obs_w = 0; obs8_w = 0; hold_bad = 0; st_bad = 0;
      en_hi = 0; tmo = 0; lat = -1; aborted = 0;
      rx_dato_out = b; rx_done = 1'b1;
      cycle();
      rx_done = 1'b0;
      latch = (b == 8'h72) ? m_cnt : pc_value;
      m_cmd = b; m_pend = 1;
      case (b)
         8'h70, 8'h72: begin exp_n = 4; exp_w = latch; exp8_w = {24'h0, latch[7:0]}; end
         8'h63, 8'h68, 8'h73, 8'h7A: begin exp_n = 1; exp_w = {24'h0, b}; exp8_w = exp_w; end
         default: begin exp_n = 1; exp_w = 32'h3F; exp8_w = 32'h3F; end
      endcase
      for (int k = 0; k < exp_n; k++) begin
         w = 0;
         while (obs_n <= k && w < 12) begin
            cycle(); w++;
            if (w == 1) pc_value = $urandom;   // latched value must not follow
         end
         if (obs_n <= k) begin tmo = 1; break; end
         if (k == 0) lat = w;
         cycle();
         if (rst_at == k) begin reset = 1'b1; cycle(); reset = 1'b0; aborted = 1; break; end
         if (drop && k == 0) begin rx_dato_out = 8'h63; rx_done = 1'b1; cycle(); rx_done = 1'b0; end
         repeat ($urandom_range(0, 2)) cycle();
         tx_done = 1'b1; cycle(); tx_done = 1'b0;
      end
      busy_after = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_dato_out = 8'h00; pc_value = 32'h0;
      repeat (3) cycle();
      n_chk++; if (enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", enable); else n_pass++;
      n_chk++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (tx_dato_in !== 8'h00) $display("FAIL reset_tx_dato: got %h want 00", tx_dato_in); else n_pass++;
      n_chk++; if ({en8, st8, busy8, dat8} !== 11'h0) $display("FAIL reset_dw8: got %h want 000", {en8, st8, busy8, dat8}); else n_pass++;
      reset = 1'b0;
      cycle();
      en_bad = 0;
   endtask

   task automatic test_step();
      do_cmd(8'h73, 0, -1);
      n_chk++; if (lat !== 2) $display("FAIL step_latency: got %0d want 2", lat); else n_pass++;
      n_chk++; if (obs_n !== 1 || obs_w !== 32'h73) $display("FAIL step_byte: got %0d/%h want 1/73", obs_n, obs_w); else n_pass++;
      n_chk++; if (obs8_w !== 32'h73) $display("FAIL step_byte_dw8: got %h want 73", obs8_w); else n_pass++;
      n_chk++; if (en_hi !== 1) $display("FAIL step_enable_cycles: got %0d want 1", en_hi); else n_pass++;
      n_chk++; if (busy_after !== 1'b0) $display("FAIL step_busy_end: got %b want 0", busy_after); else n_pass++;
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs_w !== 32'd1) $display("FAIL step_counter: got %h want 1", obs_w); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL step_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_run_read();
      do_cmd(8'h63, 0, -1);
      n_chk++; if (obs_w !== 32'h63) $display("FAIL run_echo_c: got %h want 63", obs_w); else n_pass++;
      repeat (100) cycle();
      do_cmd(8'h68, 0, -1);
      n_chk++; if (obs_w !== 32'h68) $display("FAIL run_echo_h: got %h want 68", obs_w); else n_pass++;
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs_n !== 4 || obs_w !== exp_w) $display("FAIL run_counter: got %0d/%h want 4/%h", obs_n, obs_w, exp_w); else n_pass++;
      n_chk++; if (obs_w !== 32'(en_total)) $display("FAIL run_counter_vs_enables: got %h want %h", obs_w, en_total); else n_pass++;
      n_chk++; if (obs8_n !== 1 || obs8_w !== exp8_w) $display("FAIL run_counter_dw8: got %0d/%h want 1/%h", obs8_n, obs8_w, exp8_w); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL run_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_pc();
      pc_value = 32'h12345678;
      do_cmd(8'h70, 0, -1);
      n_chk++; if (obs_n !== 4 || obs_w !== 32'h12345678) $display("FAIL pc_bytes: got %0d/%h want 4/12345678", obs_n, obs_w); else n_pass++;
      n_chk++; if (obs8_n !== 1 || obs8_w !== 32'h78) $display("FAIL pc_bytes_dw8: got %0d/%h want 1/78", obs8_n, obs8_w); else n_pass++;
      n_chk++; if (hold_bad !== 0 || st_bad !== 0) $display("FAIL pc_handshake: got hold %0d pulse %0d want 0 0", hold_bad, st_bad); else n_pass++;
      n_chk++; if (lat !== 2 || busy_after !== 1'b0) $display("FAIL pc_timing: got lat %0d busy %b want 2 0", lat, busy_after); else n_pass++;
   endtask

   task automatic test_unknown_drop();
      do_cmd(8'h78, 1, -1);
      n_chk++; if (obs_n !== 1 || obs_w !== 32'h3F) $display("FAIL unk_byte: got %0d/%h want 1/3f", obs_n, obs_w); else n_pass++;
      repeat (10) cycle();
      n_chk++; if (obs_n !== 1 || obs8_n !== 1) $display("FAIL drop_extra_bytes: got %0d/%0d want 1/1", obs_n, obs8_n); else n_pass++;
      n_chk++; if (en_hi !== 0 || enable !== 1'b0) $display("FAIL drop_enable: got %0d cycles en %b want 0 0", en_hi, enable); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL drop_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_wrap_clear();
      int g;
      do_cmd(8'h63, 0, -1);
      repeat (20) cycle();
      do_cmd(8'h7A, 0, -1);
      do_cmd(8'h68, 0, -1);
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs_w !== exp_w) $display("FAIL clear_running: got %h want %h", obs_w, exp_w); else n_pass++;
      do_cmd(8'h7A, 0, -1);
      do_cmd(8'h63, 0, -1);
      g = 0;
      while (m_cnt[7:0] < 8'd240 && g < 400) begin cycle(); g++; end
      do_cmd(8'h68, 0, -1);
      g = 0;
      while (m_cnt[7:0] != 8'hFF && g < 40) begin do_cmd(8'h73, 0, -1); g++; end
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs8_w !== 32'hFF || obs_w !== 32'hFF) $display("FAIL wrap_at_max: got %h/%h want ff/ff", obs8_w, obs_w); else n_pass++;
      do_cmd(8'h73, 0, -1);
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs8_w !== 32'h00) $display("FAIL wrap_to_zero_dw8: got %h want 00", obs8_w); else n_pass++;
      n_chk++; if (obs_w !== 32'h100) $display("FAIL wrap_dw32: got %h want 100", obs_w); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL wrap_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_reset_mid();
      do_cmd(8'h63, 0, -1);
      pc_value = $urandom;
      do_cmd(8'h70, 0, 1);
      n_chk++; if (aborted !== 1 || obs_n !== 2) $display("FAIL rstmid_bytes: got %b/%0d want 1/2", aborted, obs_n); else n_pass++;
      n_chk++; if ({tx_start, enable, busy, busy8} !== 4'b0) $display("FAIL rstmid_outputs: got %b want 0000", {tx_start, enable, busy, busy8}); else n_pass++;
      n_chk++; if (obs_w[15:0] !== exp_w[31:16]) $display("FAIL rstmid_partial: got %h want %h", obs_w[15:0], exp_w[31:16]); else n_pass++;
      repeat (6) begin repeat (3) cycle(); tx_done = 1'b1; cycle(); tx_done = 1'b0; end
      n_chk++; if (obs_n !== 2 || busy !== 1'b0) $display("FAIL rstmid_no_resume: got %0d busy %b want 2 0", obs_n, busy); else n_pass++;
      do_cmd(8'h72, 0, -1);
      n_chk++; if (obs_w !== 32'h0) $display("FAIL rstmid_counter: got %h want 0", obs_w); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL rstmid_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_reset_rx();
      reset = 1'b1; rx_dato_out = 8'h63; rx_done = 1'b1;
      cycle(); cycle();
      reset = 1'b0;
      do_cmd(8'h63, 0, -1);
      n_chk++; if (lat !== 2 || obs_w !== 32'h63) $display("FAIL rstrx_capture: got lat %0d byte %h want 2 63", lat, obs_w); else n_pass++;
      n_chk++; if (enable !== 1'b1) $display("FAIL rstrx_enable: got %b want 1", enable); else n_pass++;
      do_cmd(8'h68, 0, -1);
      n_chk++; if (enable !== 1'b0) $display("FAIL rstrx_halt: got %b want 0", enable); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL rstrx_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   task automatic test_random();
      logic [7:0] tbl [6];
      logic [7:0] b;
      int sel, hb, sb;
      tbl[0] = 8'h63; tbl[1] = 8'h68; tbl[2] = 8'h73; tbl[3] = 8'h70; tbl[4] = 8'h72; tbl[5] = 8'h7A;
      hb = 0; sb = 0;
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 8);
         b = (sel < 6) ? tbl[sel] : 8'($urandom_range(0, 255));
         pc_value = $urandom;
         repeat ($urandom_range(0, 4)) begin tx_done = 1'($urandom_range(0, 1)); cycle(); end
         tx_done = 1'b0;
         do_cmd(b, 0, -1);
         hb += hold_bad; sb += st_bad;
         n_chk++; if (tmo || obs_n !== exp_n || obs_w !== exp_w) $display("FAIL rand_resp[%0d] cmd %h: got %0d/%h want %0d/%h", i, b, obs_n, obs_w, exp_n, exp_w); else n_pass++;
         n_chk++; if (obs8_n !== 1 || obs8_w !== exp8_w) $display("FAIL rand_resp_dw8[%0d] cmd %h: got %0d/%h want 1/%h", i, b, obs8_n, obs8_w, exp8_w); else n_pass++;
         n_chk++; if (lat !== 2 || busy_after !== 1'b0) $display("FAIL rand_timing[%0d]: got lat %0d busy %b want 2 0", i, lat, busy_after); else n_pass++;
      end
      n_chk++; if (hb !== 0 || sb !== 0) $display("FAIL rand_handshake: got hold %0d pulse %0d want 0 0", hb, sb); else n_pass++;
      n_chk++; if (en_bad !== 0) $display("FAIL rand_enable_model: got %0d bad cycles want 0", en_bad); else n_pass++;
      en_bad = 0;
   endtask

   initial begin
      reset = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_dato_out = 8'h00; pc_value = 32'h0;
      obs_n = 0; obs8_n = 0; obs_w = 0; obs8_w = 0; hold_bad = 0; st_bad = 0;
      en_bad = 0; en_hi = 0; en_total = 0; holding = 0; st_prev = 0; hold_v = 8'h00;
      test_reset();
      test_step();
      test_run_read();
      test_pc();
      test_unknown_drop();
      test_wrap_clear();
      test_reset_mid();
      test_reset_rx();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
